// File: rtl/vx_tensor_pair_arbiter.sv
// Per-warp 2-deep slots feeding a round-robin pair lock; 1-cycle minimum latency; in_ready is per-warp slot space, out holds while stalled.
// Optional perf_lock_stall counter enabled by `define VX_TENSOR_PAIR_ARB_PERF_EN.
module vx_tensor_pair_arbiter #(
  parameter int NUM_WARPS = 4,
  parameter int DATAW     = 1024,
  localparam int WIDW     = $clog2(NUM_WARPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDW-1:0]  in_wid,
  input  logic             in_last,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDW-1:0]  out_wid,
  output logic             out_last,
  output logic [DATAW-1:0] out_data,
  output logic             locked,
  output logic [WIDW-1:0]  lock_wid,
`ifdef VX_TENSOR_PAIR_ARB_PERF_EN
  output logic [31:0]      perf_lock_stall,
`endif
  output logic             err
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [WIDW-1:0] WID_ONE = WIDW'(1);

  state_t               state;
  logic [DATAW:0]       slot_mem [NUM_WARPS][2];
  logic [1:0]           count [NUM_WARPS];
  logic [NUM_WARPS-1:0] rd_ptr, wr_ptr, phase;
  logic [NUM_WARPS-1:0] nonempty, head_last, eligible;
  logic [WIDW-1:0]      rr_ptr, rr_wid, rr_idx, hold_wid, sel_wid;
  logic                 rr_found, hold_vld, in_fire, out_fire;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      nonempty[w]  = (count[w] != 2'd0);
      head_last[w] = slot_mem[w][rd_ptr[w]][DATAW];
      eligible[w]  = nonempty[w] && !head_last[w];
    end
  end

  // First eligible warp at or after rr_ptr; the add wraps because NUM_WARPS is a power of 2.
  always_comb begin
    rr_found = 1'b0;
    rr_wid   = '0;
    rr_idx   = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      rr_idx = rr_ptr + WIDW'(i);
      if (!rr_found && eligible[rr_idx]) begin
        rr_found = 1'b1;
        rr_wid   = rr_idx;
      end
    end
  end

  // A stalled IDLE grant is held so a newly eligible warp cannot swap the presented uop.
  always_comb begin
    if (state == LOCKED) begin
      sel_wid   = lock_wid;
      out_valid = nonempty[lock_wid];
    end else begin
      sel_wid   = hold_vld ? hold_wid : rr_wid;
      out_valid = hold_vld || rr_found;
    end
  end

  assign out_wid               = sel_wid;
  assign {out_last, out_data}  = slot_mem[sel_wid][rd_ptr[sel_wid]];
  assign in_ready              = (count[in_wid] != 2'd2);
  assign in_fire               = in_valid && in_ready;
  assign out_fire              = out_valid && out_ready;
  assign locked                = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (in_fire)
      slot_mem[in_wid][wr_ptr[in_wid]] <= {in_last, in_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lock_wid <= '0;
      rr_ptr   <= '0;
      hold_vld <= 1'b0;
      hold_wid <= '0;
      err      <= 1'b0;
      phase    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int w = 0; w < NUM_WARPS; w++)
        count[w] <= 2'd0;
    end else begin
      if (in_fire) begin
        wr_ptr[in_wid] <= ~wr_ptr[in_wid];
        phase[in_wid]  <= ~in_last;
        if (in_last != phase[in_wid])
          err <= 1'b1;
      end
      if (out_fire)
        rd_ptr[out_wid] <= ~rd_ptr[out_wid];

      for (int w = 0; w < NUM_WARPS; w++) begin
        case ({in_fire && (in_wid == WIDW'(w)), out_fire && (out_wid == WIDW'(w))})
          2'b10:   count[w] <= count[w] + 2'd1;
          2'b01:   count[w] <= count[w] - 2'd1;
          default: count[w] <= count[w];
        endcase
      end

      case (state)
        IDLE: begin
          if (out_fire) begin
            state    <= LOCKED;
            lock_wid <= out_wid;
            rr_ptr   <= out_wid + WID_ONE;
            hold_vld <= 1'b0;
          end else if (out_valid) begin
            hold_vld <= 1'b1;
            hold_wid <= out_wid;
          end
        end
        LOCKED: begin
          hold_vld <= 1'b0;
          if (out_fire && out_last) begin
            state    <= IDLE;
            lock_wid <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VX_TENSOR_PAIR_ARB_PERF_EN
  logic other_pending;

  always_comb begin
    other_pending = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++)
      if (nonempty[w] && (WIDW'(w) != lock_wid))
        other_pending = 1'b1;
  end

  // Cycles the lock holder starves while another warp has work queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      perf_lock_stall <= '0;
    else if ((state == LOCKED) && !nonempty[lock_wid] && other_pending && (perf_lock_stall != '1))
      perf_lock_stall <= perf_lock_stall + 32'd1;
  end
`endif

endmodule

// File: tb/tb_vx_tensor_pair_arbiter.sv
// Scoreboard bench for vx_tensor_pair_arbiter: expected uops queued at drive time, checked on each output handshake.
module tb_vx_tensor_pair_arbiter;
  localparam int NW = 4;
  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]    wid;
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run = 0;
  int   fails     = 0;

  logic          clk = 1'b0, reset = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [1:0]    in_wid = 2'd0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_last, locked, err;
  logic [1:0]    out_wid, lock_wid;
  logic [DW-1:0] out_data;
`ifdef VX_TENSOR_PAIR_ARB_PERF_EN
  logic [31:0]   perf_lock_stall;
`endif

  vx_tensor_pair_arbiter #(.NUM_WARPS(NW), .DATAW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_last(in_last), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_last(out_last), .out_data(out_data),
    .locked(locked), .lock_wid(lock_wid),
`ifdef VX_TENSOR_PAIR_ARB_PERF_EN
    .perf_lock_stall(perf_lock_stall),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk(input logic [1:0] w, input logic l, input int n);
    return {6'd0, w, 7'd0, l, n[15:0]};
  endfunction

  task automatic expect_out(input logic [1:0] w, input logic l, input int n);
    exp_q.push_back(exp_t'({w, l, mk(w, l, n)}));
  endtask

  // Output handshakes are sampled on the falling edge, ahead of the rising edge that completes them.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL out_unexpected: got wid=%0d last=%0d data=%h, expected no output", out_wid, out_last, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_wid, out_last, out_data} !== mon_e) begin
          fails++;
          $display("FAIL out_order: got wid=%0d last=%0d data=%h, expected wid=%0d last=%0d data=%h",
                   out_wid, out_last, out_data, mon_e.wid, mon_e.last, mon_e.data);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic push(input logic [1:0] w, input logic l, input int n);
    bit done = 1'b0;
    in_valid = 1'b1; in_wid = w; in_last = l; in_data = mk(w, l, n);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests_run++; fails++;
      $display("FAIL push_timeout: wid=%0d never accepted, expected in_ready=1", w);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d uops still expected, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_wid = 2'd1; out_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tests_run++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
    tests_run++; if (lock_wid !== 2'd0) begin fails++; $display("FAIL reset_lock_wid: got %0d want 0", lock_wid); end
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
`ifdef VX_TENSOR_PAIR_ARB_PERF_EN
    tests_run++; if (perf_lock_stall !== 32'd0) begin fails++; $display("FAIL reset_perf: got %0d want 0", perf_lock_stall); end
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_pair();
    do_reset();
    out_ready = 1'b1;
    expect_out(2, 0, 1); expect_out(2, 1, 2);
    in_valid = 1'b1; in_wid = 2'd2; in_last = 1'b0; in_data = mk(2, 0, 1);
    @(posedge clk);
    #1 in_last = 1'b1; in_data = mk(2, 1, 2);
    @(negedge clk);
    tests_run++; if ({out_valid, out_wid, out_last, locked} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin
      fails++; $display("FAIL pair_cycle1: got v=%b wid=%0d last=%b locked=%b want v=1 wid=2 last=0 locked=0", out_valid, out_wid, out_last, locked); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if ({out_valid, out_wid, out_last, locked} !== {1'b1, 2'd2, 1'b1, 1'b1}) begin
      fails++; $display("FAIL pair_cycle2: got v=%b wid=%0d last=%b locked=%b want v=1 wid=2 last=1 locked=1", out_valid, out_wid, out_last, locked); end
    @(posedge clk);
    #1;
    @(negedge clk);
    tests_run++; if ({out_valid, locked, err} !== 3'b000) begin
      fails++; $display("FAIL pair_cycle3: got v=%b locked=%b err=%b want 0 0 0", out_valid, locked, err); end
    drain("single_pair");
  endtask

  task automatic test_no_interleave();
    do_reset();
    out_ready = 1'b0;
    expect_out(0, 0, 1); expect_out(0, 1, 2); expect_out(1, 0, 1); expect_out(1, 1, 2);
    push(0, 0, 1); push(1, 0, 1); push(1, 1, 2); push(0, 1, 2);
    out_ready = 1'b1;
    drain("no_interleave");
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL no_interleave_err: got %b want 0", err); end
  endtask

  task automatic test_round_robin();
    do_reset();
    out_ready = 1'b1;
    expect_out(0, 0, 1); expect_out(0, 1, 2); expect_out(1, 0, 1);
    expect_out(1, 1, 2); expect_out(3, 0, 1); expect_out(3, 1, 2);
    push(0, 0, 1); push(3, 0, 1); push(1, 0, 1); push(0, 1, 2); push(3, 1, 2); push(1, 1, 2);
    drain("round_robin");
    tests_run++; if ({locked, err} !== 2'b00) begin fails++; $display("FAIL round_robin_end: got locked=%b err=%b want 0 0", locked, err); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    expect_out(1, 0, 1); expect_out(1, 1, 2); expect_out(2, 0, 1);
    expect_out(2, 1, 2); expect_out(1, 0, 3); expect_out(1, 1, 4);
    push(1, 0, 1); push(1, 1, 2);
    in_valid = 1'b1; in_wid = 2'd1; in_last = 1'b0; in_data = mk(1, 0, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_slot_ready: got %b want 0", in_ready); end
      @(posedge clk);
      #1;
    end
    in_wid = 2'd2; in_data = mk(2, 0, 1);
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL other_slot_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if ({out_valid, out_wid, out_last, out_data} !== {1'b1, 2'd1, 1'b0, mk(1, 0, 1)}) begin
        fails++; $display("FAIL stall_stable: got v=%b wid=%0d last=%b data=%h want v=1 wid=1 last=0 data=%h",
                          out_valid, out_wid, out_last, out_data, mk(1, 0, 1)); end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    push(1, 0, 3); push(2, 1, 2); push(1, 1, 4);
    drain("backpressure");
    tests_run++; if (err !== 1'b0) begin fails++; $display("FAIL backpressure_err: got %b want 0", err); end
  endtask

  task automatic test_phase_err();
    do_reset();
    out_ready = 1'b1;
    push(0, 1, 1);
    @(negedge clk);
    tests_run++; if ({err, out_valid} !== 2'b10) begin fails++; $display("FAIL phase_err_set: got err=%b v=%b want err=1 v=0", err, out_valid); end
    @(posedge clk);
    #1;
    expect_out(3, 0, 1); expect_out(3, 1, 2);
    push(3, 0, 1); push(3, 1, 2);
    drain("phase_err");
    @(negedge clk);
    tests_run++; if ({err, out_valid, locked} !== 3'b100) begin
      fails++; $display("FAIL phase_err_sticky: got err=%b v=%b locked=%b want err=1 v=0 locked=0", err, out_valid, locked); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_pair();
    do_reset();
    out_ready = 1'b1;
    expect_out(0, 0, 1);
    push(0, 0, 1);
    @(posedge clk);
    #1;
    push(3, 0, 1);
    repeat (2) begin @(posedge clk); #1; end
    tests_run++; if ({locked, lock_wid, out_valid} !== {1'b1, 2'd0, 1'b0}) begin
      fails++; $display("FAIL mid_pair_locked: got locked=%b wid=%0d v=%b want locked=1 wid=0 v=0", locked, lock_wid, out_valid); end
`ifdef VX_TENSOR_PAIR_ARB_PERF_EN
    tests_run++; if (perf_lock_stall !== 32'd2) begin fails++; $display("FAIL perf_count: got %0d want 2", perf_lock_stall); end
`endif
    reset = 1'b1;
    exp_q.delete();
    in_wid = 2'd3;
    #2;
    tests_run++; if ({locked, lock_wid, out_valid, in_ready} !== {1'b0, 2'd0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL async_reset: got locked=%b wid=%0d v=%b rdy=%b want 0 0 0 1", locked, lock_wid, out_valid, in_ready); end
`ifdef VX_TENSOR_PAIR_ARB_PERF_EN
    tests_run++; if (perf_lock_stall !== 32'd0) begin fails++; $display("FAIL perf_reset: got %0d want 0", perf_lock_stall); end
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    expect_out(1, 0, 5); expect_out(1, 1, 6);
    push(1, 0, 5); push(1, 1, 6);
    drain("reset_mid_pair");
    @(negedge clk);
    tests_run++; if ({out_valid, locked, err} !== 3'b000) begin
      fails++; $display("FAIL reset_slots_empty: got v=%b locked=%b err=%b want 0 0 0", out_valid, locked, err); end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_no_interleave();
    test_round_robin();
    test_backpressure();
    test_phase_err();
    test_reset_mid_pair();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
